// File: rtl/voice_iq_fifo_pkg.sv
// Shared voice-path constants for the FIR, the voice I/Q FIFO and the bus interface,
// plus the level-counter update helper used by the FIFO.
package voice_iq_fifo_pkg;

  localparam int DDC_IQ_WIDTH           = 16;
  localparam int VOICE_FIFO_DEPTH_LOG2  = 4;
  localparam int VOICE_FIFO_READY_LEVEL = 4;

  typedef enum logic [1:0] {
    LVL_HOLD,
    LVL_INC,
    LVL_DEC
  } level_op_e;

  // A simultaneous push and pop leaves the occupancy unchanged.
  function automatic level_op_e level_op(input logic push, input logic pop_ok);
    case ({push, pop_ok})
      2'b10:   return LVL_INC;
      2'b01:   return LVL_DEC;
      default: return LVL_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/voice_iq_fifo_mem.sv
// Register-array storage for the voice I/Q FIFO: one synchronous write port and
// one asynchronous read port, cleared by reset.
module iq_fifo_mem #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // NOTE: the array is reset so the read port never exposes X after power-up;
  // this forces flops rather than a RAM macro, which is acceptable at 16 entries.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2**ADDR_W; k++) begin
        mem[k] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/voice_iq_fifo.sv
// Elastic buffer between the voice decimating FIR and the MCU parallel bus:
// captures I/Q pairs, presents the oldest pair, and reports level and sticky error flags.
module voice_iq_fifo
  import voice_iq_fifo_pkg::*;
#(
  parameter int IQ_WIDTH    = DDC_IQ_WIDTH,
  parameter int DEPTH_LOG2  = VOICE_FIFO_DEPTH_LOG2,
  parameter int READY_LEVEL = VOICE_FIFO_READY_LEVEL
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [IQ_WIDTH-1:0]   in_i,
  input  logic [IQ_WIDTH-1:0]   in_q,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  flag_clear,
  output logic [IQ_WIDTH-1:0]   out_i,
  output logic [IQ_WIDTH-1:0]   out_q,
  output logic                  out_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  iq_ready,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                 DEPTH        = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL   = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] READY_THRESH = (DEPTH_LOG2+1)'(READY_LEVEL);

  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     level_q;
  logic                    overflow_q;
  logic                    underflow_q;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop_ok;
  logic                    ovf_evt;
  logic                    unf_evt;
  logic [2*IQ_WIDTH-1:0]   head;

  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);

  // Flush overrides both strobes, so a flushed cycle neither moves data nor raises a flag.
  assign push    = !flush && in_valid && (!full || pop);
  assign pop_ok  = !flush && pop && !empty;
  assign ovf_evt = !flush && in_valid && full && !pop;
  assign unf_evt = !flush && pop && empty;

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case (level_op(push, pop_ok))
        LVL_INC: level_q <= level_q + 1'b1;
        LVL_DEC: level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // A new event in the same cycle as flag_clear wins.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_evt || (overflow_q && !flag_clear);
      underflow_q <= unf_evt || (underflow_q && !flag_clear);
    end
  end

  iq_fifo_mem #(
    .WIDTH  (2*IQ_WIDTH),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({in_i, in_q}),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // Outputs depend only on registered state; the bus sees zeros whenever the FIFO is empty.
  assign out_valid = !empty;
  assign out_i     = empty ? '0 : head[2*IQ_WIDTH-1:IQ_WIDTH];
  assign out_q     = empty ? '0 : head[IQ_WIDTH-1:0];
  assign level     = level_q;
  assign iq_ready  = (level_q >= READY_THRESH);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_voice_iq_fifo.sv
// Scoreboard bench for voice_iq_fifo: a queue-based reference model tracks expected
// contents and flags, and a negedge monitor compares every visible output against it.
module tb_voice_iq_fifo;

  localparam int W     = 16;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int RL    = 4;

  logic          clk_in     = 1'b0;
  logic          reset_n    = 1'b0;
  logic          in_valid   = 1'b0;
  logic [W-1:0]  in_i       = '0;
  logic [W-1:0]  in_q       = '0;
  logic          pop        = 1'b0;
  logic          flush      = 1'b0;
  logic          flag_clear = 1'b0;
  logic [W-1:0]  out_i;
  logic [W-1:0]  out_q;
  logic          out_valid;
  logic [DL:0]   level;
  logic          iq_ready;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] i;
    logic [W-1:0] q;
  } pair_t;

  pair_t exp_q[$];
  bit    m_ovf;
  bit    m_unf;

  voice_iq_fifo #(
    .IQ_WIDTH    (W),
    .DEPTH_LOG2  (DL),
    .READY_LEVEL (RL)
  ) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_i       (in_i),
    .in_q       (in_q),
    .pop        (pop),
    .flush      (flush),
    .flag_clear (flag_clear),
    .out_i      (out_i),
    .out_q      (out_q),
    .out_valid  (out_valid),
    .level      (level),
    .iq_ready   (iq_ready),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pairs updated from the documented rules.
  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_ovf <= 1'b0;
      m_unf <= 1'b0;
    end else if (flush) begin
      exp_q.delete();
      if (flag_clear) begin
        m_ovf <= 1'b0;
        m_unf <= 1'b0;
      end
    end else begin
      m_ovf <= (in_valid && exp_q.size() == DEPTH && !pop) || (m_ovf && !flag_clear);
      m_unf <= (pop && exp_q.size() == 0) || (m_unf && !flag_clear);
      if (in_valid && pop && exp_q.size() == DEPTH) begin
        void'(exp_q.pop_front());
        exp_q.push_back('{i: in_i, q: in_q});
      end else begin
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (in_valid && exp_q.size() < DEPTH) exp_q.push_back('{i: in_i, q: in_q});
      end
    end
  end

  // Monitor: compares everything the bus interface can see against the model.
  always @(negedge clk_in) begin
    if (reset_n) begin
      check("level", 32'(level), exp_q.size());
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("iq_ready", 32'(iq_ready), 32'(exp_q.size() >= RL));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
      if (exp_q.size() != 0) begin
        check("head_i", 32'(out_i), 32'(exp_q[0].i));
        check("head_q", 32'(out_q), 32'(exp_q[0].q));
      end else begin
        check("empty_i", 32'(out_i), 32'h0);
        check("empty_q", 32'(out_q), 32'h0);
      end
    end
  end

  task automatic step(input bit v, input logic [W-1:0] di, input logic [W-1:0] dq,
                      input bit p, input bit f, input bit fc);
    in_valid   = v;
    in_i       = di;
    in_q       = dq;
    pop        = p;
    flush      = f;
    flag_clear = fc;
    @(posedge clk_in);
    #1;
    in_valid   = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    flag_clear = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_i"}, 32'(out_i), 32'h0);
    check({tag, "_out_q"}, 32'(out_q), 32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_level"}, 32'(level), 32'h0);
    check({tag, "_iq_ready"}, 32'(iq_ready), 32'h0);
    check({tag, "_overflow"}, 32'(overflow), 32'h0);
    check({tag, "_underflow"}, 32'(underflow), 32'h0);
  endtask

  initial begin
    logic [W-1:0] nk;
    int           mode;
    bit           v, p, f, fc;

    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk_in);
    #2 reset_n = 1'b1;
    @(negedge clk_in);

    // 1: single push into empty FIFO, visible the next cycle
    step(1, 16'h1234, 16'hFFFE, 0, 0, 0);
    check("t1_out_i", 32'(out_i), 32'h1234);
    check("t1_out_q", 32'(out_q), 32'hFFFE);
    check("t1_out_valid", 32'(out_valid), 32'h1);
    check("t1_level", 32'(level), 32'h1);
    check("t1_iq_ready", 32'(iq_ready), 32'h0);
    step(0, '0, '0, 1, 0, 0);

    // 2: fill, overflow on the 17th push, then drain in order
    for (int k = 1; k <= 16; k++) begin
      nk = 16'(-k);
      step(1, 16'(k), nk, 0, 0, 0);
    end
    step(1, 16'h0BAD, 16'h0BAD, 0, 0, 0);
    check("t2_level_full", 32'(level), 32'd16);
    check("t2_overflow", 32'(overflow), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      check("t2_order", 32'(out_i), 32'(k));
      step(0, '0, '0, 1, 0, 0);
    end
    check("t2_drained_valid", 32'(out_valid), 32'h0);
    check("t2_drained_i", 32'(out_i), 32'h0);

    // 3: full FIFO with simultaneous push and pop
    step(0, '0, '0, 0, 0, 1);
    check("t3_ovf_cleared", 32'(overflow), 32'h0);
    for (int k = 1; k <= 16; k++) step(1, 16'(100 + k), 16'(200 + k), 0, 0, 0);
    step(1, 16'h7777, 16'h8888, 1, 0, 0);
    check("t3_level", 32'(level), 32'd16);
    check("t3_overflow", 32'(overflow), 32'h0);
    check("t3_head", 32'(out_i), 32'd102);
    repeat (15) step(0, '0, '0, 1, 0, 0);
    check("t3_last_i", 32'(out_i), 32'h7777);
    check("t3_last_q", 32'(out_q), 32'h8888);
    step(0, '0, '0, 1, 0, 0);

    // 4: underflow and set-wins-over-clear
    step(0, '0, '0, 1, 0, 0);
    check("t4_underflow", 32'(underflow), 32'h1);
    check("t4_level", 32'(level), 32'h0);
    step(0, '0, '0, 1, 0, 1);
    check("t4_set_wins", 32'(underflow), 32'h1);
    step(0, '0, '0, 0, 0, 1);
    check("t4_cleared", 32'(underflow), 32'h0);

    // 5: iq_ready threshold and flush priority
    for (int k = 0; k < 3; k++) step(1, 16'(k), 16'(k), 0, 0, 0);
    check("t5_below_ready", 32'(iq_ready), 32'h0);
    step(1, 16'h0033, 16'h0044, 0, 0, 0);
    check("t5_level4", 32'(level), 32'd4);
    check("t5_ready", 32'(iq_ready), 32'h1);
    step(1, 16'h0055, 16'h0066, 0, 1, 0);
    check("t5_flush_level", 32'(level), 32'h0);
    check("t5_flush_ready", 32'(iq_ready), 32'h0);
    check("t5_flush_ovf", 32'(overflow), 32'h0);
    for (int k = 0; k < 16; k++) step(1, 16'(k), 16'(k), 0, 0, 0);
    step(1, 16'h0099, 16'h0099, 0, 1, 0);
    check("t5_full_flush_ovf", 32'(overflow), 32'h0);
    check("t5_full_flush_level", 32'(level), 32'h0);

    // 6: asynchronous reset in the middle of a burst
    for (int k = 0; k < 5; k++) step(1, 16'(300 + k), 16'(400 + k), 0, 0, 0);
    in_valid = 1'b1;
    in_i     = 16'h1111;
    in_q     = 16'h2222;
    @(posedge clk_in);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    in_valid = 1'b0;
    @(negedge clk_in);
    #2 reset_n = 1'b1;
    @(negedge clk_in);
    step(1, 16'hA5A5, 16'h5A5A, 0, 0, 0);
    check("t6_read_i", 32'(out_i), 32'hA5A5);
    check("t6_read_q", 32'(out_q), 32'h5A5A);
    check("t6_level", 32'(level), 32'h1);
    step(0, '0, '0, 1, 0, 0);

    // Randomized traffic alternating fill-heavy, drain-heavy and balanced phases
    for (int n = 0; n < 3000; n++) begin
      mode = (n / 250) % 3;
      case (mode)
        0:       begin v = ($urandom_range(0, 99) < 80); p = ($urandom_range(0, 99) < 20); end
        1:       begin v = ($urandom_range(0, 99) < 20); p = ($urandom_range(0, 99) < 80); end
        default: begin v = ($urandom_range(0, 99) < 50); p = ($urandom_range(0, 99) < 50); end
      endcase
      f  = ($urandom_range(0, 99) == 0);
      fc = ($urandom_range(0, 49) == 0);
      step(v, 16'($urandom), 16'($urandom), p, f, fc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
